calc_operand_feeder: RTL and testbench

- Stage directly upstream of the three-term multiply-accumulate Calculate stage, which computes x1*y1 + x2*y2 + x3*y3 into a 16-bit result.
- Accepts a serial stream of (x, y) byte pairs over valid/ready and packs them into the three operand pairs.
- Holds the operands stable for the fixed pipeline latency of the Calculate stage, then captures its result.
- Presents each result downstream over valid/ready. Sequences the Calculate stage; contains no arithmetic of its own.

---
 rtl/calc_operand_feeder_pkg.sv | 30 +++
 rtl/calc_operand_feeder_if.sv | 28 ++
 rtl/calc_operand_feeder.sv | 142 ++++++++++++++
 tb/tb_calc_operand_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_operand_feeder_pkg.sv
// Shared types and constants for the Calculate-stage operand feeder.
package calc_feed_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned RESULT_W_DEF = 16;
  localparam int unsigned TERMS        = 3;

  // Width of the latency down-counter; holds CALC_LATENCY-1 for latencies 1..15.
  localparam int unsigned LAT_W = 4;
  // Width of the operand-pair slot index.
  localparam int unsigned IDX_W = 2;

  typedef logic [LAT_W-1:0] lat_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(TERMS - 1);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT      = 2'd1,
    HOLD      = 2'd2,
    HOLD_FULL = 2'd3
  } feed_state_t;

  // Input side is open only while collecting operands with the operand bank free.
  function automatic logic accepts_input(feed_state_t s);
    return (s == FILL) || (s == HOLD);
  endfunction

endpackage

// File: rtl/calc_operand_feeder_if.sv
// Input pair stream and output result stream of the operand feeder.
interface calc_operand_feeder_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESULT_W = 16
);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_x;
  logic [DATA_W-1:0]   in_y;

  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_data;

  // Feeder side.
  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_data
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/calc_operand_feeder.sv
// Packs a serial (x, y) pair stream into three operand registers, holds them for
// the Calculate stage latency, captures its result and offers it downstream.
module calc_operand_feeder
  import calc_feed_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned RESULT_W     = RESULT_W_DEF,
  parameter int unsigned CALC_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  calc_operand_feeder_if.slave bus,
  output logic [DATA_W-1:0]   x1,
  output logic [DATA_W-1:0]   x2,
  output logic [DATA_W-1:0]   x3,
  output logic [DATA_W-1:0]   y1,
  output logic [DATA_W-1:0]   y2,
  output logic [DATA_W-1:0]   y3,
  input  logic [RESULT_W-1:0] calc_result
);

  localparam lat_t LAT_LOAD = lat_t'(CALC_LATENCY - 1);

  feed_state_t         state_q, state_d;
  idx_t                idx_q;
  lat_t                lat_q, lat_d;
  logic                out_valid_q, out_valid_d;
  logic [RESULT_W-1:0] out_data_q, out_data_d;

  logic in_ready;
  logic in_acc;
  logic out_acc;
  logic last_pair;

  assign in_ready  = accepts_input(state_q);
  assign in_acc    = bus.in_valid && in_ready;
  assign out_acc   = out_valid_q && bus.out_ready;
  // An out-of-range index is treated as the final slot so it recovers to 0.
  assign last_pair = in_acc && (idx_q >= LAST_IDX);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Write accepted pairs into the slot selected by idx and advance idx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      x1    <= '0;
      x2    <= '0;
      x3    <= '0;
      y1    <= '0;
      y2    <= '0;
      y3    <= '0;
    end else if (in_acc) begin
      case (idx_q)
        idx_t'(0): begin
          x1 <= bus.in_x;
          y1 <= bus.in_y;
        end
        idx_t'(1): begin
          x2 <= bus.in_x;
          y2 <= bus.in_y;
        end
        default: begin
          x3 <= bus.in_x;
          y3 <= bus.in_y;
        end
      endcase
      idx_q <= last_pair ? '0 : idx_q + 1'b1;
    end
  end

  // State, latency counter and output register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state decode: sequence fill, latency wait, result hold and handoff.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      FILL: begin
        if (last_pair) begin
          state_d = WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_data_d  = calc_result;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      HOLD: begin
        // A third pair landing with the output handshake goes straight to WAIT.
        if (out_acc) begin
          out_valid_d = 1'b0;
          if (last_pair) begin
            state_d = WAIT;
            lat_d   = LAT_LOAD;
          end else begin
            state_d = FILL;
          end
        end else if (last_pair) begin
          state_d = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        // Operands have been stable since the earlier third-pair edge, so the
        // latency count may start from the handshake edge.
        if (out_acc) begin
          out_valid_d = 1'b0;
          state_d     = WAIT;
          lat_d       = LAT_LOAD;
        end
      end
      default: begin
        state_d     = FILL;
        lat_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_operand_feeder.sv
// Directed bench for calc_operand_feeder with a delay model of the Calculate stage.
module tb_calc_operand_feeder;
  import calc_feed_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned RW  = 16;
  localparam int unsigned LAT = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] x1, x2, x3, y1, y2, y3;
  logic [RW-1:0] calc_result;
  logic [RW-1:0] calc_sum;

  calc_operand_feeder_if #(.DATA_W(DW), .RESULT_W(RW)) bus ();

  calc_operand_feeder #(
    .DATA_W       (DW),
    .RESULT_W     (RW),
    .CALC_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .x1          (x1),
    .x2          (x2),
    .x3          (x3),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .calc_result (calc_result)
  );

  always #5 clk = ~clk;

  // Calculate-stage model: sum of products, valid LAT edges after the operands change.
  assign calc_sum = RW'(int'(x1) * int'(y1) + int'(x2) * int'(y2) + int'(x3) * int'(y3));

  generate
    if (LAT == 1) begin : g_comb
      assign calc_result = calc_sum;
    end else begin : g_pipe
      logic [RW-1:0] stage [LAT-1];
      always_ff @(posedge clk) begin
        stage[0] <= calc_sum;
        for (int i = 1; i < int'(LAT) - 1; i++) stage[i] <= stage[i-1];
      end
      assign calc_result = stage[LAT-2];
    end
  endgenerate

  int unsigned cyc    = 0;
  int unsigned hs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Count output handshakes to catch extra or missing result pulses.
  always @(posedge clk) if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;

  int checks   = 0;
  int failures = 0;
  int unsigned last_acc;

  typedef struct packed {
    logic [2:0][DW-1:0] x;
    logic [2:0][DW-1:0] y;
    logic [RW-1:0]      exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int a0, input int b0, input int a1,
                         input int b1, input int a2, input int b2, input int e);
    vecs[idx].x[0] = DW'(a0);
    vecs[idx].y[0] = DW'(b0);
    vecs[idx].x[1] = DW'(a1);
    vecs[idx].y[1] = DW'(b1);
    vecs[idx].x[2] = DW'(a2);
    vecs[idx].y[2] = DW'(b2);
    vecs[idx].exp  = RW'(e);
  endtask

  task automatic send_pair(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", bus.in_ready, 1);
    @(posedge clk);
    #1;
    last_acc     = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [RW-1:0] exp, input int unsigned start);
    int unsigned n = 0;
    bit ready_seen = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && n < 64) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_latency"}, cyc - start, LAT);
    check({name, "_data"}, bus.out_data, exp);
    check({name, "_wait_ready"}, ready_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned h0;

    set_vec(0,   1,   2,   3,   4,   5,   6,    44);
    set_vec(1, 255, 255, 255, 255, 255, 255, 64003);
    set_vec(2,  10,  20,   0,   0,   0,   5,   200);
    set_vec(3,  16,  16,  16,  16,  16,  16,   768);
    set_vec(4, 100, 200,  50,  50,   1,   1, 22501);
    set_vec(5, 200, 200, 200, 200, 100, 100, 24464);

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_x1", x1, 0);
    check("rst_y3", y3, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_operands", {x1, x2, x3, y1, y2, y3}, 0);

    // Table vectors, no backpressure.
    for (int i = 0; i < 6; i++) begin
      send_pair(vecs[i].x[0], vecs[i].y[0]);
      send_pair(vecs[i].x[1], vecs[i].y[1]);
      send_pair(vecs[i].x[2], vecs[i].y[2]);
      wait_result("vec", vecs[i].exp, last_acc);
      check("vec_x1", x1, vecs[i].x[0]);
      check("vec_y3", y3, vecs[i].y[2]);
      @(posedge clk);
      #1;
      check("vec_handoff_valid", bus.out_valid, 0);
      check("vec_handoff_ready", bus.in_ready, 1);
    end

    // Input gaps: idx must survive idle cycles.
    send_pair(8'd1, 8'd1);
    check("gap_x1", x1, 1);
    repeat (5) @(posedge clk);
    #1;
    check("gap_ready", bus.in_ready, 1);
    check("gap_valid", bus.out_valid, 0);
    send_pair(8'd0, 8'd0);
    repeat (5) @(posedge clk);
    #1;
    send_pair(8'd7, 8'd3);
    check("gap_x3", x3, 7);
    wait_result("gap", 16'd22, last_acc);
    @(posedge clk);
    #1;

    // Backpressure: held result, HOLD_FULL, then release.
    bus.out_ready = 1'b0;
    h0 = hs_cnt;
    send_pair(8'd1, 8'd2);
    send_pair(8'd3, 8'd4);
    send_pair(8'd5, 8'd6);
    wait_result("bp1", 16'd44, last_acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_data, 44);
    end
    send_pair(8'd2, 8'd2);
    send_pair(8'd2, 8'd2);
    send_pair(8'd2, 8'd2);
    check("bp_full_ready", bus.in_ready, 0);
    check("bp_full_valid", bus.out_valid, 1);
    check("bp_full_data", bus.out_data, 44);
    repeat (2) @(negedge clk);
    check("bp_full_ready_later", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", bus.out_valid, 0);
    wait_result("bp2", 16'd12, cyc);
    @(posedge clk);
    #1;
    check("bp_handshakes", hs_cnt - h0, 2);

    // Third pair accepted on the same edge as the output handshake.
    bus.out_ready = 1'b0;
    h0 = hs_cnt;
    send_pair(8'd1, 8'd1);
    send_pair(8'd1, 8'd1);
    send_pair(8'd1, 8'd1);
    wait_result("sim1", 16'd3, last_acc);
    send_pair(8'd4, 8'd4);
    send_pair(8'd4, 8'd4);
    check("sim_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    send_pair(8'd4, 8'd4);
    check("sim_direct_valid", bus.out_valid, 0);
    check("sim_direct_ready", bus.in_ready, 0);
    wait_result("sim2", 16'd48, last_acc);
    repeat (4) @(posedge clk);
    #1;
    check("sim_handshakes", hs_cnt - h0, 2);

    // Reset in WAIT discards the pending result and the slot index.
    h0 = hs_cnt;
    send_pair(8'd9, 8'd9);
    send_pair(8'd9, 8'd9);
    send_pair(8'd9, 8'd9);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_operands", {x1, x2, x3, y1, y2, y3}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", bus.in_ready, 1);
    send_pair(8'd1, 8'd1);
    check("mid_rst_idx_x1", x1, 1);
    check("mid_rst_idx_x2", x2, 0);
    send_pair(8'd1, 8'd1);
    send_pair(8'd1, 8'd1);
    wait_result("rst", 16'd3, last_acc);
    repeat (6) @(posedge clk);
    #1;
    check("rst_handshakes", hs_cnt - h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
